gpio_input_conditioner: RTL and testbench
=========================================

GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 Parameter WIDTH, default 10: number of independent input bits conditioned.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: depth of the metastability synchronizer per bit.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), minimum 1: consecutive cycles a new synchronized value must persist before acceptance.
REQ-004 Parameter RESET_LEVEL, default all-zero, WIDTH bits: value loaded into synchronizer and level_o on reset.
REQ-005 clk  input  1  single system clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pins_i  input  WIDTH  raw asynchronous board inputs (switches, keys).
REQ-008 clear_i  input  WIDTH  per-bit write-one-to-clear strobe for the rise_o and fall_o flags.
REQ-009 level_o  output  WIDTH  debounced stable level, registered.
REQ-010 rise_o  output  WIDTH  sticky flag, set on accepted 0->1 transition of level_o.
REQ-011 fall_o  output  WIDTH  sticky flag, set on accepted 1->0 transition of level_o.
REQ-012 change_o  output  1  single-cycle pulse when any level_o bit changes.

Function
REQ-013 Each bit SHALL pass through SYNC_STAGES flip-flops; the last stage output is the synchronized value sync[i].
REQ-014 Each bit SHALL own a counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-015 While sync[i] == level_o[i], counter[i] SHALL be 0.
REQ-016 While sync[i] != level_o[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1 per cycle.
REQ-017 When sync[i] != level_o[i] and counter[i] == DEBOUNCE_CYCLES-1, level_o[i] SHALL take sync[i] at that edge and counter[i] SHALL return to 0.
REQ-018 Any cycle with sync[i] == level_o[i] before acceptance SHALL discard progress (counter to 0); glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach level_o.
REQ-019 Latency: a pins_i change first sampled at edge t and held SHALL update level_o at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-020 rise_o[i] SHALL be set at the same edge level_o[i] goes 0->1; fall_o[i] likewise for 1->0.
REQ-021 clear_i[i] high SHALL clear rise_o[i] and fall_o[i] at the next edge.
REQ-022 Simultaneous set and clear on the same bit in the same cycle: set SHALL win (flag stays 1).
REQ-023 change_o SHALL be 1 for exactly the one cycle after any edge at which a level_o bit changed, else 0; multiple bits changing together produce one pulse.
REQ-024 Bits SHALL be fully independent; activity on one bit SHALL not affect any other bit's counter, level or flags.
REQ-025 Counters SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-026 DEBOUNCE_CYCLES == 1 SHALL accept a differing synchronized value at the first cycle it is seen.

Reset
REQ-027 On reset, all synchronizer stages and level_o SHALL load RESET_LEVEL; counters, rise_o, fall_o and change_o SHALL be 0.
REQ-028 Reset SHALL take priority over every other update, including mid-count; no transition flags SHALL be raised by reset itself.
REQ-029 After reset deasserts, pins_i differing from RESET_LEVEL SHALL be accepted through the normal REQ-019 path.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0)
REQ-030 Reset for 3 cycles with pins_i=4'hF -> level_o=0, rise_o=0, fall_o=0, change_o=0 during reset; level_o=4'hF exactly 5 cycles after reset release.
REQ-031 pins_i[0] 0->1 first sampled at edge 10, held -> level_o[0]=1 and rise_o[0]=1 from edge 15; change_o=1 only in the cycle after edge 15.
REQ-032 pins_i[1] high for 3 cycles then low -> level_o[1], rise_o[1], change_o remain 0 throughout.
REQ-033 clear_i[0] asserted in the same cycle as a new accepted rise on bit 0 -> rise_o[0] remains 1; clear_i[0] one cycle later -> rise_o[0]=0 next edge.
REQ-034 Reset asserted while counter[2]=2 -> counter[2]=0, level_o[2]=0, no flags; bits 0 and 3 toggled together -> both levels update at the same edge, single change_o pulse.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioning: multi-flop synchronizer, persistence-based debounce,
// sticky rise/fall flags with write-one-to-clear, and a one-cycle any-change pulse.
module gpio_input_conditioner #(
    parameter int               WIDTH           = 10,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_i,
    input  logic [WIDTH-1:0] clear_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;

    logic [CW-1:0]    cnt_p1 [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_p1;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_p1;
    logic [WIDTH-1:0] fall_p1;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic             change_p1;

    assign sync_w = sync_p0[SYNC_STAGES-1];

    // Stage p0: metastability synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p0[s] <= RESET_LEVEL;
            end
        end else begin
            sync_p0[0] <= pins_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p0[s] <= sync_p0[s-1];
            end
        end
    end

    // Any cycle where the synchronized bit agrees with the level discards progress.
    always_comb begin
        level_d = level_p1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != level_p1[i]) begin
                if (cnt_p1[i] == CNT_MAX) begin
                    level_d[i] = sync_w[i];
                end else begin
                    cnt_d[i] = cnt_p1[i] + CW'(1);
                end
            end
        end
        rise_set = level_d & ~level_p1;
        fall_set = ~level_d & level_p1;
    end

    // Stage p1: debounce counters, accepted level, flags and change pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p1[i] <= '0;
            end
            level_p1  <= RESET_LEVEL;
            rise_p1   <= '0;
            fall_p1   <= '0;
            change_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_p1[i] <= cnt_d[i];
            end
            level_p1  <= level_d;
            rise_p1   <= (rise_p1 & ~clear_i) | rise_set;
            fall_p1   <= (fall_p1 & ~clear_i) | fall_set;
            change_p1 <= |(level_d ^ level_p1);
        end
    end

    assign level_o  = level_p1;
    assign rise_o   = rise_p1;
    assign fall_o   = fall_p1;
    assign change_o = change_p1;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pins_i;
    logic [3:0] clear_i;
    logic [3:0] level_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic       change_o;

    int vectors = 0;
    int miscompares = 0;

    gpio_input_conditioner #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .RESET_LEVEL(4'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pins_i(pins_i),
        .clear_i(clear_i),
        .level_o(level_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .change_o(change_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pins_i = 4'hF; clear_i = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if ({level_o, rise_o, fall_o, change_o} !== 13'h0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: got lvl=%h rise=%h fall=%h chg=%b, want all 0", k, level_o, rise_o, fall_o, change_o);
            end
        end
        reset = 1'b0;
        repeat (5) step();
        vectors++;
        if (level_o !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_release_early: got lvl=%h, want 0", level_o);
        end
        step();
        vectors++;
        if (level_o !== 4'hF || rise_o !== 4'hF || fall_o !== 4'h0 || change_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_accept: got lvl=%h rise=%h fall=%h chg=%b, want F F 0 1", level_o, rise_o, fall_o, change_o);
        end
        step();
        vectors++;
        if (change_o !== 1'b0 || level_o !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_release_pulse: got lvl=%h chg=%b, want F 0", level_o, change_o);
        end
        // Return to an all-low baseline; reset itself must raise no flags.
        reset = 1'b1; pins_i = 4'h0;
        step(); step();
        vectors++;
        if ({level_o, rise_o, fall_o, change_o} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_reapply: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level_o, rise_o, fall_o, change_o);
        end
        reset = 1'b0;
        step(); step();
    endtask

    task automatic test_rise_latency();
        pins_i = 4'h1;
        repeat (5) step();
        vectors++;
        if (level_o !== 4'h0 || change_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_early: got lvl=%h chg=%b, want 0 0", level_o, change_o);
        end
        step();
        vectors++;
        if (level_o !== 4'h1 || rise_o !== 4'h1 || change_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rise_accept: got lvl=%h rise=%h chg=%b, want 1 1 1", level_o, rise_o, change_o);
        end
        step();
        vectors++;
        if (change_o !== 1'b0 || rise_o !== 4'h1) begin
            miscompares++;
            $display("FAIL rise_pulse_end: got rise=%h chg=%b, want 1 0", rise_o, change_o);
        end
    endtask

    task automatic test_glitch();
        pins_i = 4'h3;
        repeat (3) step();
        pins_i = 4'h1;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (level_o !== 4'h1 || rise_o !== 4'h1 || fall_o !== 4'h0 || change_o !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch cyc%0d: got lvl=%h rise=%h fall=%h chg=%b, want 1 1 0 0", k, level_o, rise_o, fall_o, change_o);
            end
        end
    endtask

    task automatic test_clear();
        clear_i = 4'h1;
        step();
        clear_i = 4'h0;
        vectors++;
        if (rise_o !== 4'h0 || level_o !== 4'h1) begin
            miscompares++;
            $display("FAIL clear_rise: got rise=%h lvl=%h, want 0 1", rise_o, level_o);
        end
        pins_i = 4'h0;
        repeat (6) step();
        vectors++;
        if (level_o !== 4'h0 || fall_o !== 4'h1 || rise_o !== 4'h0) begin
            miscompares++;
            $display("FAIL fall_accept: got lvl=%h fall=%h rise=%h, want 0 1 0", level_o, fall_o, rise_o);
        end
        clear_i = 4'h1;
        step();
        clear_i = 4'h0;
        vectors++;
        if (fall_o !== 4'h0) begin
            miscompares++;
            $display("FAIL clear_fall: got fall=%h, want 0", fall_o);
        end
        pins_i = 4'h1;
        repeat (5) step();
        clear_i = 4'h1;
        step();
        vectors++;
        if (rise_o !== 4'h1 || level_o !== 4'h1) begin
            miscompares++;
            $display("FAIL set_beats_clear: got rise=%h lvl=%h, want 1 1", rise_o, level_o);
        end
        step();
        clear_i = 4'h0;
        vectors++;
        if (rise_o !== 4'h0) begin
            miscompares++;
            $display("FAIL clear_after_set: got rise=%h, want 0", rise_o);
        end
    endtask

    task automatic test_reset_midcount();
        pins_i = 4'h5;
        repeat (4) step();
        reset = 1'b1;
        step();
        vectors++;
        if ({level_o, rise_o, fall_o, change_o} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_midcount: got lvl=%h rise=%h fall=%h chg=%b, want all 0", level_o, rise_o, fall_o, change_o);
        end
        reset = 1'b0;
        repeat (5) step();
        vectors++;
        if (level_o !== 4'h0) begin
            miscompares++;
            $display("FAIL midcount_not_early: got lvl=%h, want 0", level_o);
        end
        step();
        vectors++;
        if (level_o !== 4'h5 || rise_o !== 4'h5 || fall_o !== 4'h0 || change_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midcount_recover: got lvl=%h rise=%h fall=%h chg=%b, want 5 5 0 1", level_o, rise_o, fall_o, change_o);
        end
    endtask

    task automatic test_back_to_back();
        clear_i = 4'hF;
        step();
        clear_i = 4'h0;
        vectors++;
        if (rise_o !== 4'h0 || fall_o !== 4'h0) begin
            miscompares++;
            $display("FAIL multi_clear: got rise=%h fall=%h, want 0 0", rise_o, fall_o);
        end
        pins_i = 4'hC;
        repeat (5) step();
        vectors++;
        if (level_o !== 4'h5 || change_o !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_early: got lvl=%h chg=%b, want 5 0", level_o, change_o);
        end
        step();
        vectors++;
        if (level_o !== 4'hC || rise_o !== 4'h8 || fall_o !== 4'h1 || change_o !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_accept: got lvl=%h rise=%h fall=%h chg=%b, want C 8 1 1", level_o, rise_o, fall_o, change_o);
        end
        step();
        vectors++;
        if (change_o !== 1'b0 || level_o !== 4'hC) begin
            miscompares++;
            $display("FAIL multi_single_pulse: got lvl=%h chg=%b, want C 0", level_o, change_o);
        end
    endtask

    initial begin
        reset = 1'b1; pins_i = 4'h0; clear_i = 4'h0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_clear();
        test_reset_midcount();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
